// File: rtl/mips_soc_pkg.sv
// Shared types and constants for the MIPS SoC program loader.
package mips_soc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StLoad,
    StChk,
    StDone,
    StErr
  } loader_state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

endpackage

// File: rtl/mips_prog_loader_if.sv
// Host-to-loader word stream with a valid/ready handshake.
interface mips_prog_loader_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/mips_prog_loader.sv
// Framed program loader: header (length), payload words, checksum. Writes the payload into
// instruction memory and releases the core reset only after a clean, checksummed load.
module mips_prog_loader
  import mips_soc_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  mips_prog_loader_if.slave   host,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                cpu_rst_n,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [ADDR_W:0]     word_count
);

  localparam int unsigned CntW   = ADDR_W + 1;
  localparam int unsigned MaxLen = DEPTH - BASE_ADDR;

  loader_state_e     state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [CntW-1:0]   word_count_q, word_count_d;
  logic [CntW-1:0]   len_q, len_d;
  logic [DATA_W-1:0] sum_q, sum_d;

  logic            accept;
  logic            len_ok;
  logic [CntW-1:0] wc_inc;

  assign accept = host.in_valid & in_ready_q;
  assign len_ok = (host.in_data != '0) && (host.in_data <= DATA_W'(MaxLen));
  assign wc_inc = word_count_q + CntW'(1);

  always_comb begin
    state_d      = state_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rst_n_d  = cpu_rst_n_q;
    err_code_d   = err_code_q;
    word_count_d = word_count_q;
    len_d        = len_q;
    sum_d        = sum_q;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StHdr;
      end
      StHdr: begin
        if (accept) begin
          if (len_ok) begin
            state_d      = StLoad;
            len_d        = CntW'(host.in_data);
            sum_d        = '0;
            word_count_d = '0;
          end else begin
            state_d    = StErr;
            err_code_d = ERR_LEN;
          end
        end
      end
      StLoad: begin
        if (accept) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = ADDR_W'(BASE_ADDR) + word_count_q[ADDR_W-1:0];
          mem_wdata_d  = host.in_data;
          sum_d        = sum_q + host.in_data;
          word_count_d = wc_inc;
          if (wc_inc == len_q) state_d = StChk;
        end
      end
      StChk: begin
        if (accept) begin
          if (host.in_data == sum_q) begin
            state_d     = StDone;
            cpu_rst_n_d = 1'b1;
            err_code_d  = ERR_NONE;
          end else begin
            state_d    = StErr;
            err_code_d = ERR_CSUM;
          end
        end
      end
      StDone, StErr: begin
        // Restart drops the core back into reset so a running program can be replaced.
        if (start) begin
          state_d      = StHdr;
          cpu_rst_n_d  = 1'b0;
          err_code_d   = ERR_NONE;
          word_count_d = '0;
          sum_d        = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    in_ready_d = (state_d == StHdr) || (state_d == StLoad) || (state_d == StChk);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= ADDR_W'(BASE_ADDR);
      mem_wdata_q  <= '0;
      cpu_rst_n_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      word_count_q <= '0;
      len_q        <= '0;
      sum_q        <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      err_code_q   <= err_code_d;
      word_count_q <= word_count_d;
      len_q        <= len_d;
      sum_q        <= sum_d;
    end
  end

  assign host.in_ready = in_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign cpu_rst_n     = cpu_rst_n_q;
  assign err_code      = err_code_q;
  assign word_count    = word_count_q;
  assign busy          = (state_q == StHdr) || (state_q == StLoad) || (state_q == StChk);
  assign done          = (state_q == StDone);
  assign error         = (state_q == StErr);

endmodule

// File: tb/tb_mips_prog_loader.sv
// Scoreboard bench for mips_prog_loader: driver pushes expected memory writes, monitor checks them.
module tb_mips_prog_loader;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned DEPTH     = 128;
  localparam int unsigned ADDR_W    = $clog2(DEPTH);
  localparam int unsigned BASE_ADDR = 0;

  typedef logic [31:0] word_q_t[$];
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int unsigned       at;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              mem_we, cpu_rst_n, busy, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   word_count;

  mips_prog_loader_if #(.DATA_W(DATA_W)) host ();

  mips_prog_loader #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .CLK(clk), .RST(rst), .start(start), .host(host),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int unsigned cyc = 0;
  int unsigned gap_pct = 0;
  wr_t         exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every write must match the head of the expected queue, at the predicted cycle.
  always @(negedge clk) begin
    wr_t e;
    if (rst && mem_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write",
                 mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr === e.addr && mem_wdata === e.data && cyc == e.at) n_pass++;
        else $display("FAIL mem_write: got addr %0d data %h cyc %0d, expected addr %0d data %h cyc %0d",
                      mem_addr, mem_wdata, cyc, e.addr, e.data, e.at);
      end
    end
  end

  function automatic logic [31:0] sum_of(input word_q_t p);
    logic [31:0] s = '0;
    foreach (p[i]) s += p[i];
    return s;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge right after the word is accepted.
  task automatic send_word(input logic [31:0] w, input bit payload, input int idx);
    while (gap_pct != 0 && $urandom_range(0, 99) < gap_pct) begin
      host.in_valid = 1'b0;
      @(negedge clk);
    end
    host.in_valid = 1'b1;
    host.in_data  = w;
    for (int i = 0; i < 200 && !host.in_ready; i++) @(negedge clk);
    if (!host.in_ready) begin
      n_checks++;
      $display("FAIL ready_timeout: got in_ready 0 for 200 cycles, expected 1");
      host.in_valid = 1'b0;
      return;
    end
    if (payload) exp_q.push_back('{addr: ADDR_W'(BASE_ADDR + idx), data: w, at: cyc + 1});
    @(negedge clk);
    host.in_valid = 1'b0;
    host.in_data  = $urandom;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},   host.in_ready, 0);
    check({tag, "_mem_we"},     mem_we, 0);
    check({tag, "_mem_addr"},   mem_addr, BASE_ADDR);
    check({tag, "_mem_wdata"},  mem_wdata, 0);
    check({tag, "_cpu_rst_n"},  cpu_rst_n, 0);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_done"},       done, 0);
    check({tag, "_error"},      error, 0);
    check({tag, "_err_code"},   err_code, 0);
    check({tag, "_word_count"}, word_count, 0);
  endtask

  task automatic run_frame(input string tag, input logic [31:0] hdr, input word_q_t pay,
                           input logic [31:0] csum, input bit mid_start);
    bit          len_ok;
    logic [31:0] s;
    bit          good;
    pulse_start();
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_cpu_rst_n_after_start"}, cpu_rst_n, 0);
    send_word(hdr, 0, 0);
    len_ok = (hdr >= 1) && (hdr <= DEPTH - BASE_ADDR);
    s = sum_of(pay);
    if (len_ok) begin
      foreach (pay[i]) begin
        if (mid_start && i == 1) pulse_start();
        send_word(pay[i], 1, i);
      end
      send_word(csum, 0, 0);
    end
    good = len_ok && (csum == s);
    check({tag, "_done"},       done, good);
    check({tag, "_error"},      error, !good);
    check({tag, "_err_code"},   err_code, !len_ok ? 2'd1 : (good ? 2'd0 : 2'd2));
    check({tag, "_cpu_rst_n"},  cpu_rst_n, good);
    check({tag, "_word_count"}, word_count, len_ok ? hdr : 0);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_in_ready"},   host.in_ready, 0);
    check({tag, "_writes_seen"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish after 500000 time units, expected finish");
    $fatal(1);
  end

  initial begin
    word_q_t     basic;
    word_q_t     big;
    word_q_t     rnd;
    logic [31:0] cs;
    int          n;
    host.in_valid = 1'b0;
    host.in_data  = '0;
    basic = '{32'h20080005, 32'h20090007, 32'h01095020};

    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst = 1'b1;
    @(negedge clk);

    run_frame("basic", 3, basic, sum_of(basic), 0);
    run_frame("reload", 3, basic, sum_of(basic), 0);
    run_frame("bad_csum", 3, basic, 32'h4111302D, 0);
    run_frame("after_err", 3, basic, sum_of(basic), 0);
    run_frame("len_zero", 0, '{}, 0, 0);
    run_frame("len_over", DEPTH + 1, '{}, 0, 0);

    big = {};
    for (int i = 0; i < DEPTH; i++) big.push_back(32'hFFFFFFFF);
    gap_pct = 40;
    run_frame("full_gaps", DEPTH, big, sum_of(big), 1);

    for (int f = 0; f < 4; f++) begin
      rnd = {};
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) rnd.push_back($urandom);
      cs = sum_of(rnd);
      if ($urandom_range(0, 1) == 1) cs = cs ^ (32'h1 << $urandom_range(0, 31));
      run_frame($sformatf("rand%0d", f), n, rnd, cs, 0);
    end
    gap_pct = 0;

    // Async reset in the middle of a 5-word load.
    pulse_start();
    send_word(5, 0, 0);
    send_word(32'hA5A5_0001, 1, 0);
    send_word(32'hA5A5_0002, 1, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_values("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    host.in_valid = 1'b1;
    host.in_data  = 32'h0000_0003;
    repeat (4) @(negedge clk);
    check("idle_in_ready", host.in_ready, 0);
    check("idle_busy", busy, 0);
    check("idle_word_count", word_count, 0);
    host.in_valid = 1'b0;
    run_frame("post_rst", 3, basic, sum_of(basic), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
